cram_port_arb: RTL and testbench

Parametrised N-channel arbiter that multiplexes byte- and word-wide cartridge RAM clients onto the single 16-bit word-addressed PSRAM controller port. Channels include the MBC/CPU path, the savestate CRAM path and the backup (bk) load/save path. It replaces the hard-wired select in the cart top level with a request/acknowledge handshake per client. It adds:
- fixed or round-robin priority;
- per-request byte/word mode;
- read-timeout recovery.

---
 rtl/cram_arb_pkg.sv | 47 ++++
 rtl/cram_rr_pick.sv | 42 ++++
 rtl/cram_port_arb.sv | 168 ++++++++++++++++
 tb/tb_cram_port_arb.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cram_arb_pkg.sv
// Shared types and helpers for the cartridge-RAM port arbiter.
// Holds the FSM state encoding, priority-mode constants and byte-lane helpers.
package cram_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWaitRd,
        StDone
    } arb_state_e;

    localparam logic ARB_FIXED = 1'b0;
    localparam logic ARB_RR    = 1'b1;

    // Byte enables for an access; bit 1 is the high (odd-address) byte.
    function automatic logic [1:0] lane_be(input logic word, input logic odd);
        logic [1:0] be;
        if (word) begin
            be = 2'b11;
        end else if (odd) begin
            be = 2'b10;
        end else begin
            be = 2'b01;
        end
        return be;
    endfunction

    // Byte writes replicate the low byte onto both lanes; be picks the live one.
    function automatic logic [15:0] lane_wdata(input logic word, input logic [15:0] wdata);
        return word ? wdata : {wdata[7:0], wdata[7:0]};
    endfunction

    // Byte reads return the addressed lane zero-extended.
    function automatic logic [15:0] lane_rdata(input logic word, input logic odd,
                                               input logic [15:0] rdata);
        logic [15:0] val;
        if (word) begin
            val = rdata;
        end else if (odd) begin
            val = {8'h00, rdata[15:8]};
        end else begin
            val = {8'h00, rdata[7:0]};
        end
        return val;
    endfunction

endpackage

// File: rtl/cram_rr_pick.sv
// Combinational winner select: fixed (lowest index) or round-robin starting at ptr_i.
// Produces a one-hot grant and the matching binary index.
module cram_rr_pick
    import cram_arb_pkg::*;
#(
    parameter int unsigned NUM_CH = 3,
    parameter int unsigned IDX_W  = 2
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [IDX_W-1:0]  ptr_i,
    input  logic              mode_i,
    output logic [NUM_CH-1:0] gnt_o,
    output logic [IDX_W-1:0]  idx_o
);

    int unsigned base;
    int unsigned cand;
    logic        found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = 0;
        base  = (mode_i == ARB_RR) ? 32'(ptr_i) : 0;
        if (base >= NUM_CH) begin
            base = 0;
        end
        for (int off = 0; off < NUM_CH; off++) begin
            cand = base + 32'(off);
            if (cand >= NUM_CH) begin
                cand = cand - NUM_CH;
            end
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/cram_port_arb.sv
// N-channel request/acknowledge arbiter onto the single 16-bit word-addressed PSRAM port.
// One transaction at a time: IDLE grant, ISSUE strobe, optional WAIT_RD, DONE ack.
module cram_port_arb
    import cram_arb_pkg::*;
#(
    parameter int unsigned NUM_CH     = 3,
    parameter int unsigned ADDR_W     = 17,
    parameter int unsigned RR_MODE    = 0,
    parameter int unsigned RD_TIMEOUT = 255
) (
    input  logic                     clk_sys,
    input  logic                     reset_n,
    input  logic [NUM_CH-1:0]        ch_req,
    input  logic [NUM_CH-1:0]        ch_we,
    input  logic [NUM_CH-1:0]        ch_word,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
    input  logic [NUM_CH*16-1:0]     ch_wdata,
    output logic [NUM_CH-1:0]        ch_ack,
    output logic [NUM_CH*16-1:0]     ch_rdata,
    output logic [ADDR_W-2:0]        mem_addr,
    output logic                     mem_wr,
    output logic                     mem_rd,
    output logic [1:0]               mem_be,
    output logic [15:0]              mem_wdata,
    input  logic                     mem_busy,
    input  logic [15:0]              mem_rdata,
    input  logic                     mem_rvalid,
    output logic                     rd_timeout_err
);

    localparam int unsigned IdxW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned CntW = 17;
    localparam logic        Mode = (RR_MODE == 1) ? ARB_RR : ARB_FIXED;

    arb_state_e          state_q;
    logic [IdxW-1:0]     idx_q;
    logic [IdxW-1:0]     rr_ptr_q;
    logic                we_q;
    logic                word_q;
    logic                odd_q;
    logic [ADDR_W-2:0]   maddr_q;
    logic [1:0]          be_q;
    logic [15:0]         wdata_q;
    logic [NUM_CH-1:0]   ack_q;
    logic [NUM_CH*16-1:0] rdata_q;
    logic [CntW-1:0]     cnt_q;
    logic                err_q;

    logic [NUM_CH-1:0]   pick_gnt;
    logic [IdxW-1:0]     pick_idx;
    logic [IdxW-1:0]     ptr_next;
    logic                sel_we;
    logic                sel_word;
    logic [ADDR_W-1:0]   sel_addr;
    logic [15:0]         sel_wdata;
    logic                rd_timeout;
    logic [15:0]         rd_val;

    cram_rr_pick #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IdxW)
    ) u_pick (
        .req_i  (ch_req),
        .ptr_i  (rr_ptr_q),
        .mode_i (Mode),
        .gnt_o  (pick_gnt),
        .idx_o  (pick_idx)
    );

    always_comb begin
        sel_we    = 1'b0;
        sel_word  = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (pick_gnt[i]) begin
                sel_we    = ch_we[i];
                sel_word  = ch_word[i];
                sel_addr  = ch_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = ch_wdata[i*16 +: 16];
            end
        end
    end

    assign ptr_next   = (pick_idx == IdxW'(NUM_CH - 1)) ? '0 : pick_idx + 1'b1;
    // Counter starts at 2 on leaving ISSUE so it tracks the ack cycle relative to the strobe.
    assign rd_timeout = (cnt_q >= CntW'(RD_TIMEOUT));
    assign rd_val     = mem_rvalid ? lane_rdata(word_q, odd_q, mem_rdata) : 16'hFFFF;

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            rr_ptr_q <= '0;
            we_q     <= 1'b0;
            word_q   <= 1'b0;
            odd_q    <= 1'b0;
            maddr_q  <= '0;
            be_q     <= 2'b00;
            wdata_q  <= '0;
            ack_q    <= '0;
            rdata_q  <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            ack_q <= '0;
            unique case (state_q)
                StIdle: begin
                    if (|ch_req) begin
                        idx_q    <= pick_idx;
                        rr_ptr_q <= ptr_next;
                        we_q     <= sel_we;
                        word_q   <= sel_word;
                        odd_q    <= sel_addr[0];
                        maddr_q  <= sel_addr[ADDR_W-1:1];
                        be_q     <= lane_be(sel_word, sel_addr[0]);
                        wdata_q  <= lane_wdata(sel_word, sel_wdata);
                        state_q  <= StIssue;
                    end
                end
                StIssue: begin
                    if (!mem_busy) begin
                        if (we_q) begin
                            ack_q   <= NUM_CH'(1) << idx_q;
                            state_q <= StDone;
                        end else begin
                            cnt_q   <= CntW'(2);
                            state_q <= StWaitRd;
                        end
                    end
                end
                StWaitRd: begin
                    if (mem_rvalid || rd_timeout) begin
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (idx_q == IdxW'(i)) begin
                                rdata_q[i*16 +: 16] <= rd_val;
                            end
                        end
                        if (!mem_rvalid) begin
                            err_q <= 1'b1;
                        end
                        ack_q   <= NUM_CH'(1) << idx_q;
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Strobes depend on mem_busy in the same cycle so exactly one accepted command is issued.
    assign mem_wr         = (state_q == StIssue) && !mem_busy && we_q;
    assign mem_rd         = (state_q == StIssue) && !mem_busy && !we_q;
    assign mem_be         = (state_q == StIssue) ? be_q : 2'b00;
    assign mem_addr       = maddr_q;
    assign mem_wdata      = wdata_q;
    assign ch_ack         = ack_q;
    assign ch_rdata       = rdata_q;
    assign rd_timeout_err = err_q;

endmodule

// File: tb/tb_cram_port_arb.sv
// Directed bench for cram_port_arb: a fixed-priority and a round-robin instance share stimulus.
module tb_cram_port_arb;

    localparam int unsigned NCH = 3;
    localparam int unsigned AW  = 17;

    logic              clk_sys = 1'b0;
    logic              reset_n;
    logic [NCH-1:0]    ch_req;
    logic [NCH-1:0]    ch_we;
    logic [NCH-1:0]    ch_word;
    logic [NCH*AW-1:0] ch_addr;
    logic [NCH*16-1:0] ch_wdata;
    logic              mem_busy;
    logic [15:0]       mem_rdata;
    logic              mem_rvalid;

    logic [NCH-1:0]    ack_fx, ack_rr;
    logic [NCH*16-1:0] rdata_fx, rdata_rr;
    logic [AW-2:0]     maddr_fx, maddr_rr;
    logic              wr_fx, wr_rr, rd_fx, rd_rr, err_fx, err_rr;
    logic [1:0]        be_fx, be_rr;
    logic [15:0]       wdata_fx, wdata_rr;

    int checks   = 0;
    int failures = 0;

    always #5 clk_sys = ~clk_sys;

    cram_port_arb #(
        .NUM_CH     (NCH),
        .ADDR_W     (AW),
        .RR_MODE    (0),
        .RD_TIMEOUT (8)
    ) dut_fx (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .ch_req         (ch_req),
        .ch_we          (ch_we),
        .ch_word        (ch_word),
        .ch_addr        (ch_addr),
        .ch_wdata       (ch_wdata),
        .ch_ack         (ack_fx),
        .ch_rdata       (rdata_fx),
        .mem_addr       (maddr_fx),
        .mem_wr         (wr_fx),
        .mem_rd         (rd_fx),
        .mem_be         (be_fx),
        .mem_wdata      (wdata_fx),
        .mem_busy       (mem_busy),
        .mem_rdata      (mem_rdata),
        .mem_rvalid     (mem_rvalid),
        .rd_timeout_err (err_fx)
    );

    cram_port_arb #(
        .NUM_CH     (NCH),
        .ADDR_W     (AW),
        .RR_MODE    (1),
        .RD_TIMEOUT (8)
    ) dut_rr (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .ch_req         (ch_req),
        .ch_we          (ch_we),
        .ch_word        (ch_word),
        .ch_addr        (ch_addr),
        .ch_wdata       (ch_wdata),
        .ch_ack         (ack_rr),
        .ch_rdata       (rdata_rr),
        .mem_addr       (maddr_rr),
        .mem_wr         (wr_rr),
        .mem_rd         (rd_rr),
        .mem_be         (be_rr),
        .mem_wdata      (wdata_rr),
        .mem_busy       (mem_busy),
        .mem_rdata      (mem_rdata),
        .mem_rvalid     (mem_rvalid),
        .rd_timeout_err (err_rr)
    );

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic smp();
        @(negedge clk_sys);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic set_ch(input int ch, input logic we, input logic word,
                          input logic [AW-1:0] addr, input logic [15:0] wd);
        ch_req[ch]            = 1'b1;
        ch_we[ch]             = we;
        ch_word[ch]           = word;
        ch_addr[ch*AW +: AW]  = addr;
        ch_wdata[ch*16 +: 16] = wd;
    endtask

    initial begin
        logic [2:0] exp_rr;
        ch_req     = '0;
        ch_we      = '0;
        ch_word    = '0;
        ch_addr    = '0;
        ch_wdata   = '0;
        mem_busy   = 1'b0;
        mem_rdata  = '0;
        mem_rvalid = 1'b0;
        reset_n    = 1'b0;

        // Reset state
        repeat (3) step();
        smp();
        chk("rst_ack", ack_fx, 0);
        chk("rst_wr", wr_fx, 0);
        chk("rst_rd", rd_fx, 0);
        chk("rst_be", be_fx, 0);
        chk("rst_err", err_fx, 0);
        chk("rst_addr", maddr_fx, 0);
        chk("rst_wdata", wdata_fx, 0);
        chk("rst_rdata", rdata_fx, 0);
        step();
        reset_n = 1'b1;
        step();

        // Channel 0 byte write at odd address
        set_ch(0, 1'b1, 1'b0, 17'h00003, 16'h005A);
        smp();
        chk("bw_c0_wr", wr_fx, 0);
        step(); smp();
        chk("bw_c1_wr", wr_fx, 1);
        chk("bw_c1_addr", maddr_fx, 16'h0001);
        chk("bw_c1_be", be_fx, 2'b10);
        chk("bw_c1_wdata", wdata_fx, 16'h5A5A);
        chk("bw_c1_ack", ack_fx, 0);
        step(); smp();
        chk("bw_c2_ack", ack_fx, 3'b001);
        chk("bw_c2_wr", wr_fx, 0);
        ch_req[0] = 1'b0;
        step(); smp();
        chk("bw_c3_ack", ack_fx, 0);

        // Channel 2 word read, rvalid three cycles after mem_rd
        step();
        set_ch(2, 1'b0, 1'b1, 17'h1F000, 16'h0000);
        step(); smp();
        chk("wr_c1_rd", rd_fx, 1);
        chk("wr_c1_addr", maddr_fx, 16'hF800);
        chk("wr_c1_be", be_fx, 2'b11);
        chk("wr_c1_wr", wr_fx, 0);
        step(); smp();
        chk("wr_c2_ack", ack_fx, 0);
        step();
        step();
        mem_rvalid = 1'b1;
        mem_rdata  = 16'hBEEF;
        smp();
        chk("wr_c4_ack", ack_fx, 0);
        step();
        mem_rvalid = 1'b0;
        mem_rdata  = 16'h0000;
        smp();
        chk("wr_c5_ack", ack_fx, 3'b100);
        chk("wr_c5_rdata", rdata_fx[47:32], 16'hBEEF);
        chk("wr_c5_err", err_fx, 0);
        ch_req[2] = 1'b0;

        // Channel 2 byte read at odd address, minimum latency
        step();
        set_ch(2, 1'b0, 1'b0, 17'h1F001, 16'h0000);
        step(); smp();
        chk("br_c1_rd", rd_fx, 1);
        chk("br_c1_be", be_fx, 2'b10);
        chk("br_c1_addr", maddr_fx, 16'hF800);
        step();
        mem_rvalid = 1'b1;
        mem_rdata  = 16'hBEEF;
        smp();
        chk("br_c2_ack", ack_fx, 0);
        step();
        mem_rvalid = 1'b0;
        smp();
        chk("br_c3_ack", ack_fx, 3'b100);
        chk("br_c3_rdata", rdata_fx[47:32], 16'h00BE);
        ch_req[2] = 1'b0;

        // Channel 1 byte write at even address
        step();
        set_ch(1, 1'b1, 1'b0, 17'h00010, 16'hAB12);
        step(); smp();
        chk("be_c1_wr", wr_fx, 1);
        chk("be_c1_be", be_fx, 2'b01);
        chk("be_c1_wdata", wdata_fx, 16'h1212);
        chk("be_c1_addr", maddr_fx, 16'h0008);
        step(); smp();
        chk("be_c2_ack", ack_fx, 3'b010);
        ch_req[1] = 1'b0;

        // Channel 1 word write, addr[0] ignored
        step();
        set_ch(1, 1'b1, 1'b1, 17'h00005, 16'hCAFE);
        step(); smp();
        chk("ww_c1_wr", wr_fx, 1);
        chk("ww_c1_be", be_fx, 2'b11);
        chk("ww_c1_wdata", wdata_fx, 16'hCAFE);
        chk("ww_c1_addr", maddr_fx, 16'h0002);
        step(); smp();
        chk("ww_c2_ack", ack_fx, 3'b010);
        ch_req[1] = 1'b0;

        // mem_busy held for five ISSUE cycles
        step();
        set_ch(1, 1'b1, 1'b1, 17'h00020, 16'h1357);
        mem_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(); smp();
            chk("busy_hold_wr", wr_fx, 0);
        end
        step();
        mem_busy = 1'b0;
        smp();
        chk("busy_rel_wr", wr_fx, 1);
        chk("busy_rel_ack", ack_fx, 0);
        step(); smp();
        chk("busy_ack", ack_fx, 3'b010);
        chk("busy_wr_once", wr_fx, 0);
        ch_req[1] = 1'b0;

        // Read timeout with RD_TIMEOUT = 8, then a late rvalid
        step();
        set_ch(0, 1'b0, 1'b1, 17'h00004, 16'h0000);
        step(); smp();
        chk("to_c1_rd", rd_fx, 1);
        repeat (7) step();
        smp();
        chk("to_c8_ack", ack_fx, 0);
        chk("to_c8_err", err_fx, 0);
        step(); smp();
        chk("to_c9_ack", ack_fx, 3'b001);
        chk("to_c9_rdata", rdata_fx[15:0], 16'hFFFF);
        chk("to_c9_err", err_fx, 1);
        ch_req[0] = 1'b0;
        step();
        mem_rvalid = 1'b1;
        mem_rdata  = 16'h1234;
        step();
        mem_rvalid = 1'b0;
        smp();
        chk("late_rdata", rdata_fx[15:0], 16'hFFFF);
        chk("late_err", err_fx, 1);
        chk("late_ack", ack_fx, 0);

        // Reset asserted during WAIT_RD
        step();
        set_ch(2, 1'b0, 1'b1, 17'h00100, 16'h0000);
        step(); smp();
        chk("mr_c1_rd", rd_fx, 1);
        step();
        reset_n = 1'b0;
        step(); smp();
        chk("mr_ack", ack_fx, 0);
        chk("mr_rd", rd_fx, 0);
        chk("mr_wr", wr_fx, 0);
        chk("mr_be", be_fx, 0);
        chk("mr_err", err_fx, 0);
        chk("mr_addr", maddr_fx, 0);
        chk("mr_wdata", wdata_fx, 0);
        chk("mr_rdata", rdata_fx, 0);
        ch_req = '0;
        step();
        reset_n = 1'b1;
        step();

        // All channels requesting continuously: round-robin vs fixed
        ch_req  = 3'b111;
        ch_we   = 3'b111;
        ch_word = 3'b111;
        for (int k = 0; k < 6; k++) begin
            if (k != 0) begin
                step();
            end
            step();
            step();
            smp();
            exp_rr = 3'b001 << (k % 3);
            chk("rr_grant", ack_rr, exp_rr);
            chk("fx_grant", ack_fx, 3'b001);
        end
        ch_req = '0;
        step(); smp();
        chk("end_ack_rr", ack_rr, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
